// File: rtl/rv_alu.sv
// Registered RV32I execute-stage ALU: decodes opcode/funct3/funct7, one-cycle latency.
// Optional RV32M multiply support is enabled by defining RV_ALU_MUL_EN.
module rv_alu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] Op1,
    input  logic [XLEN-1:0] Op2,
    output logic [XLEN-1:0] Rez,
    output logic            out_valid,
    output logic            illegal
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    logic [31:0] result_s;
    logic        illegal_s;
    logic [31:0] rez_r;
    logic        illegal_r;
    logic        out_valid_r;

    // Shared funct3 datapath for OP and OP-IMM; alt selects SUB / SRA.
    function automatic logic [31:0] alu_f3(input logic [2:0] f3, input logic alt,
                                           input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        r = 32'h0;
        case (f3)
            3'b000: begin
                if (alt) begin
                    r = a - b;
                end else begin
                    r = a + b;
                end
            end
            3'b001: r = a << b[4:0];
            3'b010: r = {31'h0, ($signed(a) < $signed(b))};
            3'b011: r = {31'h0, (a < b)};
            3'b100: r = a ^ b;
            3'b101: begin
                if (alt) begin
                    r = $unsigned($signed(a) >>> b[4:0]);
                end else begin
                    r = a >> b[4:0];
                end
            end
            3'b110: r = a | b;
            3'b111: r = a & b;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    // Branch condition evaluation; unsupported encodings report not-taken.
    function automatic logic branch_taken(input logic [2:0] f3,
                                          input logic [31:0] a, input logic [31:0] b);
        logic t;
        t = 1'b0;
        case (f3)
            3'b000:  t = (a == b);
            3'b001:  t = (a != b);
            3'b100:  t = ($signed(a) < $signed(b));
            3'b101:  t = ($signed(a) >= $signed(b));
            3'b110:  t = (a < b);
            3'b111:  t = (a >= b);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

`ifdef RV_ALU_MUL_EN
    logic        mul_ext_a_s;
    logic        mul_ext_b_s;
    logic [63:0] mul_prod_s;
    logic [31:0] mul_res_s;
    logic        mul_ill_s;

    // One 64-bit multiplier; operand sign extension picks MUL/MULH/MULHSU/MULHU.
    always_comb begin
        mul_ext_a_s = (funct3 == 3'b001) || (funct3 == 3'b010);
        mul_ext_b_s = (funct3 == 3'b001);
        mul_prod_s  = {(mul_ext_a_s ? {32{Op1[31]}} : 32'h0), Op1}
                    * {(mul_ext_b_s ? {32{Op2[31]}} : 32'h0), Op2};
        mul_res_s   = 32'h0;
        mul_ill_s   = 1'b0;
        case (funct3)
            3'b000:  mul_res_s = mul_prod_s[31:0];
            3'b001,
            3'b010,
            3'b011:  mul_res_s = mul_prod_s[63:32];
            default: mul_ill_s = 1'b1;
        endcase
    end
`endif

    // Instruction decode and result selection.
    always_comb begin
        result_s  = 32'h0;
        illegal_s = 1'b0;
        case (opcode)
            OPC_LUI: result_s = Op2;
            OPC_AUIPC,
            OPC_LOAD,
            OPC_STORE: result_s = Op1 + Op2;
            OPC_JAL,
            OPC_JALR: result_s = Op1 + 32'd4;
            OPC_OPIMM: begin
                // funct7 is immediate payload except on shifts.
                if (funct3 == 3'b001) begin
                    if (funct7 == F7_BASE) begin
                        result_s = alu_f3(funct3, 1'b0, Op1, Op2);
                    end else begin
                        illegal_s = 1'b1;
                    end
                end else if (funct3 == 3'b101) begin
                    if (funct7 == F7_BASE) begin
                        result_s = alu_f3(funct3, 1'b0, Op1, Op2);
                    end else if (funct7 == F7_ALT) begin
                        result_s = alu_f3(funct3, 1'b1, Op1, Op2);
                    end else begin
                        illegal_s = 1'b1;
                    end
                end else begin
                    result_s = alu_f3(funct3, 1'b0, Op1, Op2);
                end
            end
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    result_s = alu_f3(funct3, 1'b0, Op1, Op2);
                end else if (funct7 == F7_ALT) begin
                    if ((funct3 == 3'b000) || (funct3 == 3'b101)) begin
                        result_s = alu_f3(funct3, 1'b1, Op1, Op2);
                    end else begin
                        illegal_s = 1'b1;
                    end
                end else if (funct7 == F7_MULDIV) begin
`ifdef RV_ALU_MUL_EN
                    result_s  = mul_res_s;
                    illegal_s = mul_ill_s;
`else
                    illegal_s = 1'b1;
`endif
                end else begin
                    illegal_s = 1'b1;
                end
            end
            OPC_BRANCH: begin
                if ((funct3 == 3'b010) || (funct3 == 3'b011)) begin
                    illegal_s = 1'b1;
                end else begin
                    result_s = {31'h0, branch_taken(funct3, Op1, Op2)};
                end
            end
            default: illegal_s = 1'b1;
        endcase
    end

    // Output registers; idle cycles hold the last result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rez_r       <= 32'h0;
            illegal_r   <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= in_valid;
            if (in_valid) begin
                rez_r     <= result_s;
                illegal_r <= illegal_s;
            end else begin
                rez_r     <= rez_r;
                illegal_r <= illegal_r;
            end
        end
    end

    assign Rez       = rez_r;
    assign illegal   = illegal_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_rv_alu.sv
// Directed-vector scoreboard bench for rv_alu; expectations are hand-computed.
// Expects RV_ALU_MUL_EN to be defined or not consistently with the RTL build.
module tb_rv_alu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] Op1;
    logic [31:0] Op2;
    logic [31:0] Rez;
    logic        out_valid;
    logic        illegal;

    typedef struct {
        logic [31:0] rez;
        logic        ill;
        int          id;
    } exp_t;

    exp_t        sb[$];
    int          n_vec;
    int          n_bad;
    int          next_id;
    logic        chk_idle;
    logic [31:0] hold_rez;
    logic        hold_ill;

    rv_alu #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7    (funct7),
        .Op1       (Op1),
        .Op2       (Op2),
        .Rez       (Rez),
        .out_valid (out_valid),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ei);
        exp_t e;
        @(posedge clk);
        #1;
        opcode   = op;
        funct3   = f3;
        funct7   = f7;
        Op1      = a;
        Op2      = b;
        in_valid = 1'b1;
        e.rez    = er;
        e.ill    = ei;
        e.id     = next_id;
        next_id  = next_id + 1;
        sb.push_back(e);
    endtask

    task automatic go_idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        exp_t e;
        n_vec    = 0;
        n_bad    = 0;
        next_id  = 0;
        chk_idle = 1'b0;
        hold_rez = 32'h0;
        hold_ill = 1'b0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        opcode   = 7'h0;
        funct3   = 3'h0;
        funct7   = 7'h0;
        Op1      = 32'h0;
        Op2      = 32'h0;

        // Monitor: pops the scoreboard whenever the DUT presents a result.
        fork
            forever begin
                @(negedge clk);
                if (out_valid === 1'b1) begin
                    n_vec = n_vec + 1;
                    if (sb.size() == 0) begin
                        n_bad = n_bad + 1;
                        $display("FAIL unexpected_out_valid: Rez=%h illegal=%b with empty scoreboard", Rez, illegal);
                    end else begin
                        e = sb.pop_front();
                        if ((Rez !== e.rez) || (illegal !== e.ill)) begin
                            n_bad = n_bad + 1;
                            $display("FAIL vec%0d: Rez=%h illegal=%b, expected Rez=%h illegal=%b",
                                     e.id, Rez, illegal, e.rez, e.ill);
                        end
                    end
                end else if (chk_idle) begin
                    n_vec = n_vec + 1;
                    if ((Rez !== hold_rez) || (illegal !== hold_ill)) begin
                        n_bad = n_bad + 1;
                        $display("FAIL idle_hold: Rez=%h illegal=%b, expected Rez=%h illegal=%b",
                                 Rez, illegal, hold_rez, hold_ill);
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #2;
        n_vec = n_vec + 1;
        if ((Rez !== 32'h0) || (out_valid !== 1'b0) || (illegal !== 1'b0)) begin
            n_bad = n_bad + 1;
            $display("FAIL reset_state: Rez=%h out_valid=%b illegal=%b, expected 0/0/0", Rez, out_valid, illegal);
        end
        rst_n = 1'b1;

        // Basic group, Op1=3 Op2=2
        drive(7'b0110111, 3'b000, 7'b0000000, 32'd3, 32'd2, 32'd2, 1'b0);          // LUI
        drive(7'b0010011, 3'b000, 7'b0000000, 32'd3, 32'd2, 32'd5, 1'b0);          // ADDI
        drive(7'b0000011, 3'b010, 7'b0000000, 32'd3, 32'd2, 32'd5, 1'b0);          // LW
        drive(7'b1100011, 3'b000, 7'b1111111, 32'd3, 32'd2, 32'd0, 1'b0);          // BEQ
        drive(7'b1100011, 3'b001, 7'b1111111, 32'd3, 32'd2, 32'd1, 1'b0);          // BNE
        drive(7'b1100011, 3'b010, 7'b0000000, 32'd3, 32'd2, 32'd0, 1'b1);          // branch f3=010
        drive(7'b0010011, 3'b101, 7'b0000000, 32'd3, 32'd2, 32'd0, 1'b0);          // SRLI
        drive(7'b1101111, 3'b000, 7'b0000000, 32'd3, 32'd2, 32'd7, 1'b0);          // JAL
        drive(7'b0110011, 3'b101, 7'b0100000, 32'h80000000, 32'd4, 32'hF8000000, 1'b0); // SRA
        drive(7'b0110011, 3'b010, 7'b0000000, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0);   // SLT
        drive(7'b0110011, 3'b011, 7'b0000000, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0);   // SLTU
        drive(7'b1111111, 3'b000, 7'b0000000, 32'd3, 32'd2, 32'd0, 1'b1);          // bad opcode
        // Additional coverage
        drive(7'b0010111, 3'b000, 7'b0000000, 32'h00001000, 32'h00005000, 32'h00006000, 1'b0); // AUIPC
        drive(7'b1100111, 3'b000, 7'b0000000, 32'hFFFFFFFE, 32'd8, 32'h00000002, 1'b0); // JALR wrap
        drive(7'b0100011, 3'b111, 7'b0000000, 32'd100, 32'hFFFFFFFC, 32'd96, 1'b0);     // STORE
        drive(7'b0010011, 3'b001, 7'b0000000, 32'h00000003, 32'd31, 32'h80000000, 1'b0); // SLLI
        drive(7'b0010011, 3'b001, 7'b0100000, 32'd3, 32'd2, 32'd0, 1'b1);          // SLLI bad f7
        drive(7'b0010011, 3'b101, 7'b0100000, 32'h80000000, 32'd1, 32'hC0000000, 1'b0); // SRAI
        drive(7'b0010011, 3'b101, 7'b0000001, 32'd3, 32'd2, 32'd0, 1'b1);          // SRLI bad f7
        drive(7'b0010011, 3'b100, 7'b1111111, 32'hF0F0F0F0, 32'hFFFFFFFF, 32'h0F0F0F0F, 1'b0); // XORI
        drive(7'b0110011, 3'b110, 7'b0000000, 32'h0000F000, 32'h000000F0, 32'h0000F0F0, 1'b0); // OR
        drive(7'b0110011, 3'b111, 7'b0000000, 32'h0000FF00, 32'h00F0F000, 32'h0000F000, 1'b0); // AND
        drive(7'b0110011, 3'b001, 7'b0100000, 32'd3, 32'd2, 32'd0, 1'b1);          // OP alt f3=001
        drive(7'b0110011, 3'b000, 7'b0010000, 32'd3, 32'd2, 32'd0, 1'b1);          // OP bad f7
        drive(7'b1100011, 3'b100, 7'b0000000, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0);   // BLT
        drive(7'b1100011, 3'b101, 7'b0000000, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0);   // BGE
        drive(7'b1100011, 3'b110, 7'b0000000, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0);   // BLTU
        drive(7'b1100011, 3'b111, 7'b0000000, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0);   // BGEU
`ifdef RV_ALU_MUL_EN
        drive(7'b0110011, 3'b011, 7'b0000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0); // MULHU
        drive(7'b0110011, 3'b000, 7'b0000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0); // MUL
        drive(7'b0110011, 3'b001, 7'b0000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0); // MULH
        drive(7'b0110011, 3'b010, 7'b0000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0); // MULHSU
        drive(7'b0110011, 3'b100, 7'b0000001, 32'd7, 32'd2, 32'd0, 1'b1);          // DIV
`else
        drive(7'b0110011, 3'b011, 7'b0000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b1);
        drive(7'b0110011, 3'b000, 7'b0000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b1);
`endif
        drive(7'b0110011, 3'b000, 7'b0100000, 32'd0, 32'd1, 32'hFFFFFFFF, 1'b0);   // SUB
        go_idle();

        // Idle: result must hold, no output strobes
        @(posedge clk);
        #1;
        hold_rez = 32'hFFFFFFFF;
        hold_ill = 1'b0;
        chk_idle = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk_idle = 1'b0;

        // Capture a result, then reset asynchronously before it is consumed
        opcode   = 7'b0110111;
        funct3   = 3'b000;
        funct7   = 7'b0000000;
        Op1      = 32'd0;
        Op2      = 32'h12345000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        n_vec = n_vec + 1;
        if ((Rez !== 32'h0) || (out_valid !== 1'b0) || (illegal !== 1'b0)) begin
            n_bad = n_bad + 1;
            $display("FAIL async_reset: Rez=%h out_valid=%b illegal=%b, expected 0/0/0", Rez, out_valid, illegal);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        drive(7'b0010011, 3'b110, 7'b0000000, 32'h00000050, 32'h00000005, 32'h00000055, 1'b0); // ORI after reset
        go_idle();

        for (int i = 0; i < 10; i++) begin
            if (sb.size() != 0) begin
                @(posedge clk);
            end else begin
                break;
            end
        end
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_vec = n_vec + 1;
            n_bad = n_bad + 1;
            $display("FAIL drain: %0d results never presented, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/rv_alu.md
Name: rv_alu

Overview:
- Registered RV32I integer ALU for the execute stage.
- Decodes the raw opcode/funct3/funct7 instruction fields together with two pre-selected 32-bit operands and produces one 32-bit result.
- Op1 is rs1 or PC; Op2 is rs2 or a decoded immediate, both selected upstream.
- Result and flags are registered: one-cycle latency.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands and fields valid this cycle
- opcode  in  7  instruction bits [6:0]
- funct3  in  3  instruction bits [14:12]
- funct7  in  7  instruction bits [31:25]
- Op1  in  32  operand 1 (rs1, or PC for AUIPC/JAL/JALR)
- Op2  in  32  operand 2 (rs2 or immediate; U-type immediate already shifted left by 12)
- Rez  out  32  registered result
- out_valid  out  1  Rez valid, equals in_valid delayed one cycle
- illegal  out  1  registered: unsupported opcode/funct combination

Behaviour:
- Reset (rst_n low, asynchronous) clears Rez=0, out_valid=0, illegal=0. Reset asserted mid-operation discards the in-flight result.
- Every rising edge with in_valid=1 captures the result computed from the current inputs. out_valid=1 in the following cycle.
- Cycles with in_valid=0: Rez and illegal hold their values; out_valid=0. No backpressure.
- Arithmetic is modulo 2^32 with no overflow flag.
- Shift amount is Op2[4:0]. SRA/SRAI replicate Op1[31].
- LUI 0110111: Rez=Op2.
- AUIPC 0010111: Rez=Op1+Op2.
- JAL 1101111 and JALR 1100111: Rez=Op1+4 (link address).
- LOAD 0000011 and STORE 0100011: Rez=Op1+Op2 (effective address). funct3 is not checked.
- OP-IMM 0010011, selected by funct3:
  - 000 ADD, 010 SLT signed, 011 SLTU, 100 XOR, 110 OR, 111 AND.
  - 001 SLL; requires funct7=0000000.
  - 101 SRL when funct7=0000000, SRA when funct7=0100000.
  - Any other funct7 on a shift -> illegal.
- OP 0110011: same funct3 mapping as OP-IMM. funct7=0100000 selects SUB (f3=000) or SRA (f3=101). funct7 must be 0000000, or 0100000 with f3 000/101; anything else -> illegal.
- SLT/SLTU results are 32'h1 or 32'h0.
- BRANCH 1100011: Rez=32'h1 if the condition is taken, else 0. funct3 conditions: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU. funct3 010/011 -> Rez=0 and illegal=1. funct7 is ignored (it holds immediate bits).
- Any other opcode: Rez=0, illegal=1.

Optional Feature:
- Macro RV_ALU_MUL_EN.
- Defined: opcode OP with funct7=0000001 executes RV32M multiplies:
  - f3 000 MUL (low 32 bits).
  - f3 001 MULH (signed×signed, high 32).
  - f3 010 MULHSU (high 32).
  - f3 011 MULHU (high 32).
  - f3 1xx (divides) -> Rez=0, illegal=1.
- Latency stays one cycle.
- Not defined: funct7=0000001 on OP -> Rez=0, illegal=1.

Test Plan:
- Reset, then Op1=3, Op2=2:
  - opcode 0110111 (LUI) -> Rez=2.
  - opcode 0010011, f3=000 (ADDI) -> Rez=5.
  - opcode 0000011, f3=010 (LW) -> Rez=5.
  - All with out_valid=1 one cycle after in_valid and illegal=0.
- Branch, Op1=3, Op2=2: opcode 1100011, f3=000, f7=1111111 (BEQ) -> Rez=0. Same operands with f3=001 -> Rez=1. f3=010 -> illegal=1.
- Shifts and jump, Op1=3, Op2=2:
  - opcode 0010011, f3=101, f7=0000000 (SRLI) -> Rez=0.
  - opcode 1101111 (JAL) -> Rez=7.
  - opcode 0110011, f3=101, f7=0100000, Op1=32'h80000000, Op2=4 (SRA) -> Rez=32'hF8000000.
- OP group:
  - SUB Op1=0, Op2=1 -> 32'hFFFFFFFF.
  - SLT Op1=32'hFFFFFFFF, Op2=1 -> 1.
  - SLTU with the same operands -> 0.
  - opcode 1111111 -> Rez=0, illegal=1.
- Handshake: in_valid=0 for several cycles -> Rez held, out_valid=0. Assert rst_n=0 between clock edges -> Rez and out_valid clear immediately, without waiting for a clock edge.
- With RV_ALU_MUL_EN defined:
  - MULHU Op1=Op2=32'hFFFFFFFF -> 32'hFFFFFFFE.
  - MUL with the same operands -> 1.
- Without RV_ALU_MUL_EN: any funct7=0000001 on OP -> illegal=1.
